// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding read request, IF/ID output registers and a one-entry hold buffer.
// Optional misaligned-fetch detection is enabled by defining IF_MISALIGN_CHK_EN.
module if_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stallreq_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign_o
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic        rst_done;
  logic        drop;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        hold_mis;
  logic        id_mis;
  logic        misaligned;
  logic [31:0] fetch_addr;

`ifdef IF_MISALIGN_CHK_EN
  assign misaligned       = (pc_i[1:0] != 2'b00);
  assign fetch_addr       = pc_i;
  assign fetch_misalign_o = id_mis;
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};
`else
  assign misaligned = 1'b0;
  assign fetch_addr = {pc_i[31:2], 2'b00};
  logic unused_bits;
  assign unused_bits = ^{stall[5:2], stall[0], pc_i[1:0], id_mis};
`endif

  assign stallreq_o = ((state == REQ) && !mem_ack_i) || (state == HOLD);

  // rst_done blocks issue on the first edge after reset release; flush always beats stall[1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rst_done   <= 1'b0;
      drop       <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
      id_pc_o    <= 32'h0;
      id_inst_o  <= 32'h0;
      id_valid_o <= 1'b0;
      id_mis     <= 1'b0;
      hold_pc    <= 32'h0;
      hold_inst  <= 32'h0;
      hold_mis   <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        IDLE: begin
          if (flush_i) begin
            id_valid_o <= 1'b0;
            id_mis     <= 1'b0;
          end else if (ce_i && rst_done && misaligned) begin
            if (stall[1]) begin
              hold_pc   <= pc_i;
              hold_inst <= NOP;
              hold_mis  <= 1'b1;
              state     <= HOLD;
            end else begin
              id_pc_o    <= pc_i;
              id_inst_o  <= NOP;
              id_valid_o <= 1'b1;
              id_mis     <= 1'b1;
            end
          end else begin
            if (ce_i && rst_done) begin
              mem_req_o  <= 1'b1;
              mem_addr_o <= fetch_addr;
              state      <= REQ;
            end
            if (!stall[1]) id_valid_o <= 1'b0;
          end
        end

        REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            drop      <= 1'b0;
            state     <= IDLE;
            if (drop || flush_i) begin
              id_valid_o <= 1'b0;
              id_mis     <= 1'b0;
            end else if (stall[1]) begin
              hold_pc   <= mem_addr_o;
              hold_inst <= mem_rdata_i;
              hold_mis  <= 1'b0;
              state     <= HOLD;
            end else begin
              id_pc_o    <= mem_addr_o;
              id_inst_o  <= mem_rdata_i;
              id_valid_o <= 1'b1;
              id_mis     <= 1'b0;
            end
          end else if (flush_i) begin
            drop       <= 1'b1;
            id_valid_o <= 1'b0;
            id_mis     <= 1'b0;
          end else if (!stall[1]) begin
            id_valid_o <= 1'b0;
          end
        end

        HOLD: begin
          if (flush_i) begin
            id_valid_o <= 1'b0;
            id_mis     <= 1'b0;
            state      <= IDLE;
          end else if (!stall[1]) begin
            id_pc_o    <= hold_pc;
            id_inst_o  <= hold_inst;
            id_valid_o <= 1'b1;
            id_mis     <= hold_mis;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed sequences, a vector table and a randomized run against a reference model.
// Build with IF_MISALIGN_CHK_EN defined to exercise the misaligned-fetch port.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stallreq;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IF_MISALIGN_CHK_EN
  logic        mis;
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int pass_count = 0;
  int check_count = 0;
  int lat = 1;
  int cnt;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_i        (pc),
    .ce_i        (ce),
    .stall       (stall),
    .flush_i     (flush),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata),
    .stallreq_o  (stallreq),
    .id_pc_o     (id_pc),
    .id_inst_o   (id_inst),
    .id_valid_o  (id_valid)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .fetch_misalign_o (mis)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 + a;
  endfunction

  // Memory answers in the lat-th cycle that the request is high.
  assign mem_ack   = mem_req && (cnt >= lat - 1);
  assign mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (mem_ack) cnt <= 0;
    else if (mem_req) cnt <= cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: tracks an outstanding fetch, a parked instruction and what ID should see.
  logic        m_armed, m_busy, m_kill, m_held, m_hmis;
  logic [31:0] m_hpc, m_hinst;
  logic        e_req, e_valid, e_mis;
  logic [31:0] e_addr, e_pc, e_inst;

  task automatic model_reset();
    m_armed = 0; m_busy = 0; m_kill = 0; m_held = 0; m_hmis = 0;
    m_hpc = 0; m_hinst = 0;
    e_req = 0; e_valid = 0; e_mis = 0; e_addr = 0; e_pc = 0; e_inst = 0;
  endtask

  task automatic model_edge(input logic ack, input logic [31:0] rdata);
    logic got, squash, gmis;
    logic [31:0] gpc, ginst;
    got = 0; squash = flush; gmis = 0; gpc = 0; ginst = 0;
    if (m_busy) begin
      if (ack) begin
        m_busy = 0;
        e_req  = 0;
        if (m_kill || flush) squash = 1;
        else if (stall[1]) begin m_held = 1; m_hpc = e_addr; m_hinst = rdata; m_hmis = 0; end
        else begin got = 1; gpc = e_addr; ginst = rdata; end
        m_kill = 0;
      end else if (flush) m_kill = 1;
    end else if (m_held) begin
      if (flush) m_held = 0;
      else if (!stall[1]) begin m_held = 0; got = 1; gpc = m_hpc; ginst = m_hinst; gmis = m_hmis; end
    end else if (!flush && ce && m_armed) begin
      if (CHK && pc[1:0] != 2'b00) begin
        if (stall[1]) begin m_held = 1; m_hpc = pc; m_hinst = 32'h13; m_hmis = 1; end
        else begin got = 1; gpc = pc; ginst = 32'h13; gmis = 1; end
      end else begin
        m_busy = 1;
        e_req  = 1;
        e_addr = CHK ? pc : {pc[31:2], 2'b00};
      end
    end
    if (got) begin e_valid = 1; e_pc = gpc; e_inst = ginst; e_mis = gmis; end
    else if (squash) begin e_valid = 0; e_mis = 0; end
    else if (!stall[1]) e_valid = 0;
    m_armed = 1;
  endtask

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          hold;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    int          e_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    logic seen;

    vecs[0] = '{32'h0000_0100, 1, 0, 32'h0000_0100, 32'h0050_0193, 1};
    vecs[1] = '{32'h0000_0104, 2, 0, 32'h0000_0104, 32'h0050_0197, 2};
    vecs[2] = '{32'h0000_0200, 4, 0, 32'h0000_0200, 32'h0050_0293, 4};
    vecs[3] = '{32'h0000_0300, 1, 2, 32'h0000_0300, 32'h0050_0393, 3};
    vecs[4] = '{32'h0000_0304, 3, 1, 32'h0000_0304, 32'h0050_0397, 3};
    vecs[5] = '{32'hFFFF_FFFC, 2, 0, 32'hFFFF_FFFC, 32'h0050_008F, 2};
    vecs[6] = '{32'h8000_0000, 1, 0, 32'h8000_0000, 32'h8050_0093, 1};
    vecs[7] = '{32'h1234_5678, 2, 3, 32'h1234_5678, 32'h1284_570B, 4};

    // Reset values and first fetch after release
    rst_n = 0; ce = 1; pc = 0; stall = 0; flush = 0; lat = 1;
    tick(); tick();
    check_output("rst_req", mem_req, 0);
    check_output("rst_addr", mem_addr, 0);
    check_output("rst_valid", id_valid, 0);
    check_output("rst_pc", id_pc, 0);
    check_output("rst_inst", id_inst, 0);
    check_output("rst_stallreq", stallreq, 0);
    rst_n = 1;
    tick();
    check_output("first_edge_no_req", mem_req, 0);
    tick();
    check_output("first_req", mem_req, 1);
    check_output("first_addr", mem_addr, 0);
    ce = 0;
    tick();
    check_output("first_valid", id_valid, 1);
    check_output("first_inst", id_inst, 32'h0050_0093);
    check_output("first_pc", id_pc, 0);
    check_output("first_req_drop", mem_req, 0);

    // Three-cycle ack latency
    pc = 32'h8; lat = 3; ce = 1;
    tick();
    check_output("lat3_req", mem_req, 1);
    check_output("lat3_addr0", mem_addr, 32'h8);
    check_output("lat3_stallreq0", stallreq, 1);
    ce = 0; pc = 32'h50;
    tick();
    check_output("lat3_addr1", mem_addr, 32'h8);
    check_output("lat3_stallreq1", stallreq, 1);
    tick();
    check_output("lat3_addr2", mem_addr, 32'h8);
    check_output("lat3_stallreq2", stallreq, 0);
    tick();
    check_output("lat3_valid", id_valid, 1);
    check_output("lat3_pc", id_pc, 32'h8);
    check_output("lat3_inst", id_inst, 32'h0050_009B);
    check_output("lat3_req_drop", mem_req, 0);

    // Ack under stall goes to HOLD with ID frozen
    pc = 32'h20; lat = 1; ce = 1; stall[1] = 1;
    tick();
    check_output("hold_req", mem_req, 1);
    check_output("hold_addr", mem_addr, 32'h20);
    check_output("hold_keep_valid", id_valid, 1);
    ce = 0;
    tick();
    check_output("hold_stallreq", stallreq, 1);
    check_output("hold_req_drop", mem_req, 0);
    check_output("hold_frozen_pc", id_pc, 32'h8);
    check_output("hold_frozen_inst", id_inst, 32'h0050_009B);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("hold_stallreq_n", stallreq, 1);
      check_output("hold_frozen_pc_n", id_pc, 32'h8);
    end
    stall[1] = 0;
    #1;
    check_output("hold_release_stallreq", stallreq, 1);
    tick();
    check_output("hold_out_valid", id_valid, 1);
    check_output("hold_out_pc", id_pc, 32'h20);
    check_output("hold_out_inst", id_inst, 32'h0050_00B3);
    check_output("hold_out_stallreq", stallreq, 0);
    tick();
    check_output("bubble_valid", id_valid, 0);

    // Flush during REQ drops the late ack
    pc = 32'h10; lat = 3; ce = 1;
    tick();
    check_output("flush_req", mem_req, 1);
    check_output("flush_addr", mem_addr, 32'h10);
    ce = 0; flush = 1;
    tick();
    flush = 0;
    check_output("flush_req_held", mem_req, 1);
    check_output("flush_valid0", id_valid, 0);
    tick();
    check_output("flush_ack_now", mem_ack, 1);
    pc = 32'h40; ce = 1;
    tick();
    lat = 1;
    check_output("flush_ack_req", mem_req, 0);
    check_output("flush_ack_valid", id_valid, 0);
    tick();
    check_output("refetch_req", mem_req, 1);
    check_output("refetch_addr", mem_addr, 32'h40);
    ce = 0;
    tick();
    check_output("refetch_valid", id_valid, 1);
    check_output("refetch_pc", id_pc, 32'h40);
    check_output("refetch_inst", id_inst, 32'h0050_00D3);

    // Asynchronous reset in the middle of a request
    pc = 32'h80; lat = 4; ce = 1; stall[1] = 1;
    tick();
    check_output("arst_req_before", mem_req, 1);
    check_output("arst_valid_before", id_valid, 1);
    #2 rst_n = 0;
    #1;
    check_output("arst_req", mem_req, 0);
    check_output("arst_valid", id_valid, 0);
    check_output("arst_addr", mem_addr, 0);
    check_output("arst_pc", id_pc, 0);
    ce = 0; stall = 0;
    tick();
    rst_n = 1;
    tick();

    // Flush coinciding with ack
    pc = 32'h60; lat = 1; ce = 1;
    tick();
    check_output("coflush_req", mem_req, 1);
    ce = 0; flush = 1;
    tick();
    flush = 0;
    check_output("coflush_req_drop", mem_req, 0);
    check_output("coflush_valid", id_valid, 0);
    tick();
    check_output("coflush_valid_after", id_valid, 0);
    check_output("coflush_no_refetch", mem_req, 0);

    // Flush beats stall in HOLD
    pc = 32'h70; lat = 1; ce = 1; stall[1] = 1;
    tick();
    ce = 0;
    tick();
    check_output("hflush_in_hold", stallreq, 1);
    flush = 1;
    tick();
    check_output("hflush_stallreq", stallreq, 0);
    check_output("hflush_valid", id_valid, 0);
    flush = 0; stall = 0;
    tick();
    check_output("hflush_no_ghost", id_valid, 0);

    // Misaligned fetch address
    pc = 32'h6; lat = 1; ce = 1;
`ifdef IF_MISALIGN_CHK_EN
    tick();
    check_output("mis_no_req", mem_req, 0);
    check_output("mis_valid", id_valid, 1);
    check_output("mis_inst", id_inst, 32'h13);
    check_output("mis_pc", id_pc, 32'h6);
    check_output("mis_flag", mis, 1);
    ce = 0;
    tick();
    check_output("mis_bubble", id_valid, 0);
    check_output("mis_flag_kept", mis, 1);
    flush = 1;
    tick();
    flush = 0;
    check_output("mis_flag_flushed", mis, 0);
`else
    tick();
    check_output("align_req", mem_req, 1);
    check_output("align_addr", mem_addr, 32'h4);
    ce = 0;
    tick();
    check_output("align_valid", id_valid, 1);
    check_output("align_pc", id_pc, 32'h4);
    check_output("align_inst", id_inst, 32'h0050_0097);
`endif
    tick();

    // Vector table: fetch with given latency and stall window
    for (int i = 0; i < 8; i++) begin
      pc = vecs[i].pc; lat = vecs[i].lat; ce = 1; stall = 0; flush = 0;
      tick();
      check_output("tbl_req", mem_req, 1);
      check_output("tbl_addr", mem_addr, vecs[i].e_addr);
      ce = 0; n = 0; seen = 0;
      for (int k = 1; k <= 30 && !seen; k++) begin
        stall[1] = (k <= vecs[i].hold);
        tick();
        if (id_valid) begin seen = 1; n = k; end
      end
      check_output("tbl_seen", seen, 1);
      check_output("tbl_cycles", n, vecs[i].e_cyc);
      check_output("tbl_pc", id_pc, vecs[i].e_addr);
      check_output("tbl_inst", id_inst, vecs[i].e_inst);
      stall = 0;
      tick(); tick();
    end

    // Randomized run against the reference model
    rst_n = 0; ce = 0; stall = 0; flush = 0;
    tick();
    model_reset();
    rst_n = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!m_busy) lat = $urandom_range(1, 4);
      ce = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
      stall = 6'($urandom);
      stall[1] = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 11) == 0);
      #2;
      check_output("rnd_stallreq", stallreq, (m_busy && !mem_ack) || m_held);
      model_edge(mem_ack, mem_rdata);
      tick();
      check_output("rnd_req", mem_req, e_req);
      check_output("rnd_addr", mem_addr, e_addr);
      check_output("rnd_valid", id_valid, e_valid);
      check_output("rnd_pc", id_pc, e_pc);
      check_output("rnd_inst", id_inst, e_inst);
`ifdef IF_MISALIGN_CHK_EN
      check_output("rnd_mis", mis, e_mis);
`endif
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
